// File: rtl/lock_controller_if.sv
// Handshake bundle between the lock controller and its attempt/command sources.
// LOCK_CONTROLLER_DOOR_SENSE_EN adds the door_closed input.
interface lock_controller_if;
    logic       attempt_valid;
    logic       attempt_ok;
    logic       lock_cmd;
    logic       locked;
    logic       lockout;
    logic [3:0] fail_cnt;
    logic       accept;
    logic       reject;
`ifdef LOCK_CONTROLLER_DOOR_SENSE_EN
    logic       door_closed;

    modport master (output attempt_valid, attempt_ok, lock_cmd, door_closed,
                    input  locked, lockout, fail_cnt, accept, reject);
    modport slave  (input  attempt_valid, attempt_ok, lock_cmd, door_closed,
                    output locked, lockout, fail_cnt, accept, reject);
`else
    modport master (output attempt_valid, attempt_ok, lock_cmd,
                    input  locked, lockout, fail_cnt, accept, reject);
    modport slave  (input  attempt_valid, attempt_ok, lock_cmd,
                    output locked, lockout, fail_cnt, accept, reject);
`endif
endinterface

// File: rtl/lock_controller.sv
// Lock-state arbiter feeding the servo PWM stage: unlock with auto-relock, brute-force lockout.
// Optional door sensing (timer hold, pending lock) is enabled by LOCK_CONTROLLER_DOOR_SENSE_EN.
module lock_controller #(
    parameter int RELOCK_CYCLES  = 250000000,
    parameter int LOCKOUT_CYCLES = 1500000000,
    parameter int MAX_FAILS      = 3
) (
    input logic               clk,
    input logic               rst_n,
    lock_controller_if.slave  bus
);

    localparam int TIMER_MAX = (RELOCK_CYCLES > LOCKOUT_CYCLES) ? RELOCK_CYCLES : LOCKOUT_CYCLES;
    localparam int TIMER_W   = $clog2(TIMER_MAX + 1);
    localparam logic [TIMER_W-1:0] RELOCK_LOAD  = TIMER_W'(RELOCK_CYCLES);
    localparam logic [TIMER_W-1:0] LOCKOUT_LOAD = TIMER_W'(LOCKOUT_CYCLES);
    localparam logic [TIMER_W-1:0] TIMER_ONE    = TIMER_W'(1);
    localparam logic [3:0]         FAIL_LIMIT   = 4'(MAX_FAILS);

    typedef enum logic [1:0] {LOCKED, UNLOCKED, LOCKOUT} state_t;

    state_t               state, state_nxt;
    logic [TIMER_W-1:0]   timer, timer_nxt;
    logic [3:0]           fails_nxt;
    logic                 accept_nxt, reject_nxt;
    logic                 good, bad, expire, lock_now, hold;
`ifdef LOCK_CONTROLLER_DOOR_SENSE_EN
    logic                 run, run_nxt;
    logic                 pend, pend_nxt;
`endif

    assign good   = bus.attempt_valid & bus.attempt_ok;
    assign bad    = bus.attempt_valid & ~bus.attempt_ok;
    assign expire = (timer == TIMER_ONE);

    always_comb begin
        state_nxt  = state;
        timer_nxt  = timer;
        fails_nxt  = bus.fail_cnt;
        accept_nxt = 1'b0;
        reject_nxt = 1'b0;
        lock_now   = bus.lock_cmd;
        hold       = 1'b0;
`ifdef LOCK_CONTROLLER_DOOR_SENSE_EN
        run_nxt    = run;
        pend_nxt   = pend;
`endif
        case (state)
            LOCKED: begin
                if (good) begin
                    state_nxt  = UNLOCKED;
                    timer_nxt  = RELOCK_LOAD;
                    fails_nxt  = 4'd0;
                    accept_nxt = 1'b1;
`ifdef LOCK_CONTROLLER_DOOR_SENSE_EN
                    run_nxt    = 1'b0;
                    pend_nxt   = 1'b0;
`endif
                end else if (bad) begin
                    reject_nxt = 1'b1;
                    if (bus.fail_cnt < FAIL_LIMIT) fails_nxt = bus.fail_cnt + 4'd1;
                    if (bus.fail_cnt + 4'd1 == FAIL_LIMIT) begin
                        state_nxt = LOCKOUT;
                        timer_nxt = LOCKOUT_LOAD;
                    end
                end
            end
            UNLOCKED: begin
`ifdef LOCK_CONTROLLER_DOOR_SENSE_EN
                // Until the door is first seen closed, the timer is parked and lock requests wait.
                if (!run) begin
                    if (!bus.door_closed) begin
                        hold     = 1'b1;
                        lock_now = 1'b0;
                        pend_nxt = pend | bus.lock_cmd;
                    end else begin
                        run_nxt  = 1'b1;
                        lock_now = bus.lock_cmd | pend;
                        pend_nxt = 1'b0;
                    end
                end
`endif
                if (lock_now) begin
                    state_nxt = LOCKED;
                    timer_nxt = '0;
                end else if (good) begin
                    timer_nxt  = RELOCK_LOAD;
                    accept_nxt = 1'b1;
                end else begin
                    reject_nxt = bad;
                    if (hold) begin
                        timer_nxt = RELOCK_LOAD;
                    end else if (expire) begin
                        state_nxt = LOCKED;
                        timer_nxt = '0;
                    end else begin
                        timer_nxt = timer - TIMER_ONE;
                    end
                end
            end
            LOCKOUT: begin
                reject_nxt = bus.attempt_valid;
                if (expire) begin
                    state_nxt = LOCKED;
                    timer_nxt = '0;
                    fails_nxt = 4'd0;
                end else begin
                    timer_nxt = timer - TIMER_ONE;
                end
            end
            default: begin
                state_nxt = LOCKED;
                timer_nxt = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= LOCKED;
            timer        <= '0;
            bus.fail_cnt <= 4'd0;
            bus.locked   <= 1'b1;
            bus.lockout  <= 1'b0;
            bus.accept   <= 1'b0;
            bus.reject   <= 1'b0;
`ifdef LOCK_CONTROLLER_DOOR_SENSE_EN
            run          <= 1'b0;
            pend         <= 1'b0;
`endif
        end else begin
            state        <= state_nxt;
            timer        <= timer_nxt;
            bus.fail_cnt <= fails_nxt;
            bus.locked   <= (state_nxt != UNLOCKED);
            bus.lockout  <= (state_nxt == LOCKOUT);
            bus.accept   <= accept_nxt;
            bus.reject   <= reject_nxt;
`ifdef LOCK_CONTROLLER_DOOR_SENSE_EN
            run          <= run_nxt;
            pend         <= pend_nxt;
`endif
        end
    end

endmodule
